// File: rtl/tt_stim_seq.sv
// tt_stim_seq: clocked sweep of every N_IN-bit input vector, each held DWELL cycles, with a sample strobe.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     begin a sweep (honoured only in IDLE or DONE)
//   pause     freezes the dwell counter and suppresses sample while high
//   vec       stimulus vector (vec[0] drives the LSB input of the gate)
//   vec_valid high while vec carries a sweep vector
//   vec_idx   binary index of the current vector
//   sample    one-cycle strobe on the last settled cycle of each vector
//   busy      high while sweeping
//   done      high after the last vector; sticky until start or rst
// Optional: define TT_STIM_SEQ_GRAY_ORDER_EN to emit vectors in Gray-code order.
module tt_stim_seq #(
  parameter int N_IN  = 3,
  parameter int DWELL = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pause,
  output logic [N_IN-1:0] vec,
  output logic            vec_valid,
  output logic [N_IN-1:0] vec_idx,
  output logic            sample,
  output logic            busy,
  output logic            done
);
  localparam int DW = $clog2(DWELL);
  localparam logic [DW-1:0] LAST_CNT = DW'(DWELL - 1);
  localparam logic [N_IN-1:0] LAST_IDX = '1;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [DW-1:0] r_cnt, w_cnt_nxt;
  logic [N_IN-1:0] r_idx, w_idx_nxt, r_vec, w_vec_nxt;
  logic r_valid, r_busy, r_done, w_go;
  assign w_go = start & (r_state != DRIVE);
  assign sample = (r_state == DRIVE) & (r_cnt == LAST_CNT) & ~pause;
`ifdef TT_STIM_SEQ_GRAY_ORDER_EN
  assign w_vec_nxt = w_idx_nxt ^ (w_idx_nxt >> 1);
`else
  assign w_vec_nxt = w_idx_nxt;
`endif
  // The terminal index is checked before incrementing, so vec_idx never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    if (w_go) begin
      w_state_nxt = DRIVE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else if (sample) begin
      if (r_idx == LAST_IDX) w_state_nxt = DONE;
      else begin
        w_idx_nxt = r_idx + N_IN'(1);
        w_cnt_nxt = '0;
      end
    end else if (r_state == DRIVE && !pause) w_cnt_nxt = r_cnt + DW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_vec   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_vec   <= w_vec_nxt;
      r_valid <= w_state_nxt == DRIVE;
      r_busy  <= w_state_nxt == DRIVE;
      r_done  <= w_state_nxt == DONE;
    end
  end
  assign vec       = r_vec;
  assign vec_idx   = r_idx;
  assign vec_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule

// File: tb/tb_tt_stim_seq.sv
// tb_tt_stim_seq: directed scoreboard bench for tt_stim_seq (N_IN=3, DWELL=10).
module tb_tt_stim_seq;
  logic clk, rst, start, pause;
  logic [2:0] vec, vec_idx;
  logic vec_valid, sample, busy, done, z;
  typedef struct {logic [2:0] v; logic [2:0] i; int c;} exp_t;
  exp_t q[$];
  int checks, errors, t, t0, busy_cnt;
  logic [7:0] zt;
  tt_stim_seq #(.N_IN(3), .DWELL(10)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .vec(vec), .vec_valid(vec_valid),
    .vec_idx(vec_idx), .sample(sample), .busy(busy), .done(done)
  );
  assign z = (vec[2] & ~vec[0]) ^ (vec[1] & vec[0]);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [2:0] ev(int i);
    logic [2:0] b;
    b = 3'(i);
`ifdef TT_STIM_SEQ_GRAY_ORDER_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_sweep(int pidx, int plen);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.v = ev(i);
      e.i = 3'(i);
      e.c = 10 * (i + 1) + (i >= pidx ? plen : 0);
      q.push_back(e);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    t++;
    if (busy) busy_cnt++;
    if (sample) begin
      if (q.size() == 0) chk("unexpected_sample", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sample_vec", vec, e.v);
        chk("sample_idx", vec_idx, e.i);
        chk("sample_cycle", t - t0, e.c);
        chk("gate_z", z, zt[e.v]);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic go();
    busy_cnt = 0;
    start = 1'b1;
    cyc();
    t0 = t;
    start = 1'b0;
  endtask
  task automatic to_cycle(int c);
    for (int n = 0; n < 200 && (t - t0) < c; n++) cyc();
  endtask
  task automatic finish_sweep(int drive);
    for (int n = 0; n < 300 && !done; n++) cyc();
    chk("done_timeout", done, 1);
    chk("drive_cycles", busy_cnt, drive);
    chk("end_valid", vec_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_vec", vec, ev(7));
    chk("end_idx", vec_idx, 7);
    chk("queue_empty", q.size(), 0);
  endtask
  initial begin
    checks = 0; errors = 0; t = 0; t0 = 0; busy_cnt = 0;
    zt = 8'b1101_1000;
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    cyc(); cyc();
    chk("rst_vec", vec, 0);
    chk("rst_idx", vec_idx, 0);
    chk("rst_valid", vec_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    cyc();
    chk("idle_busy", busy, 0);
    push_sweep(8, 0);
    go();
    chk("start_valid", vec_valid, 1);
    chk("start_busy", busy, 1);
    chk("start_vec", vec, 0);
    chk("start_idx", vec_idx, 0);
    finish_sweep(80);
    cyc(); cyc();
    chk("done_sticky", done, 1);
    chk("done_vec_hold", vec, ev(7));
    push_sweep(3, 5);
    go();
    chk("restart_done_clr", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_idx", vec_idx, 0);
    to_cycle(32);
    chk("pre_pause_idx", vec_idx, 3);
    pause = 1'b1;
    for (int n = 0; n < 5; n++) begin
      chk("pause_no_sample", sample, 0);
      cyc();
    end
    pause = 1'b0;
    chk("post_pause_idx", vec_idx, 3);
    chk("post_pause_vec", vec, ev(3));
    to_cycle(50);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_in_drive_idx", vec_idx, 4);
    chk("start_in_drive_busy", busy, 1);
    finish_sweep(85);
    push_sweep(8, 0);
    go();
    to_cycle(53);
    chk("pre_rst_idx", vec_idx, 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vec", vec, 0);
    chk("async_rst_idx", vec_idx, 0);
    chk("async_rst_valid", vec_valid, 0);
    chk("async_rst_sample", sample, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    start = 1'b1;
    cyc(); cyc();
    chk("start_in_rst_busy", busy, 0);
    chk("start_in_rst_valid", vec_valid, 0);
    rst = 1'b0;
    start = 1'b0;
    cyc();
    chk("after_rst_busy", busy, 0);
    q.delete();
    push_sweep(8, 0);
    go();
    chk("resweep_idx", vec_idx, 0);
    chk("resweep_vec", vec, 0);
    finish_sweep(80);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
